iomem_timer: RTL and testbench
==============================

IOMEM_TIMER -- requirements
Module: iomem_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0300_0000, meaning the base of a 32-byte register window, 32-byte aligned.
REQ-002 SHALL have port clk, input, 1, the system clock.
REQ-003 SHALL have port reset_n, input, 1, reset (synchronous, active-low).
REQ-004 SHALL have port mem_valid, input, 1, the native-bus request valid signal from the CPU.
REQ-005 SHALL have port mem_addr, input, 32, the byte address.
REQ-006 SHALL have port mem_wdata, input, 32, the write data.
REQ-007 SHALL have port mem_wstrb, input, 4, the byte write strobes; 4'b0000 means a read.
REQ-008 SHALL have port mem_ready, output, 1, the transfer-complete pulse.
REQ-009 SHALL have port mem_rdata, output, 32, the read data, valid only while mem_ready=1.
REQ-010 SHALL have port irq, output, 1, the timer-expired interrupt request (level).
REQ-011 SHALL have port pwm_out, output, 4, the PWM channel outputs.

Function
REQ-012 SHALL treat sel = mem_valid && mem_addr[31:5]==BASE_ADDR[31:5] as a hit; register offset = mem_addr[4:2].
REQ-013 SHALL assert mem_ready for exactly one cycle, the cycle after sel is sampled with mem_ready=0: ready <= sel && !ready; zero-wait responses are forbidden.
REQ-014 SHALL apply each write on the sel sampling edge, honouring every mem_wstrb bit independently per byte lane.
REQ-015 SHALL register mem_rdata on the same edge, and drive it to 32'h0 whenever mem_ready=0.
REQ-016 SHALL map these registers: 0 CTRL[3:0] (b0 EN, b1 AUTORELOAD, b2 IRQ_EN, b3 PWM_EN); 1 PRESCALE[15:0]; 2 RELOAD[31:0]; 3 COUNT[31:0] (read live, write loads); 4 STATUS[0] EXPIRED (write-1-to-clear); 5 DUTY[31:0] (byte i = channel i).
REQ-017 SHALL, for offsets 6-7 and for unused bits, read 0, ignore writes, and still complete with mem_ready.
REQ-018 SHALL run a prescaler counting 0..PRESCALE; tick = (prescaler==PRESCALE), after which the prescaler returns to 0; PRESCALE=0 gives a tick every cycle.
REQ-019 SHALL run the prescaler while EN=1 or PWM_EN=1, and hold it at 0 otherwise.
REQ-020 SHALL, on a tick with EN=1 and COUNT!=0, decrement COUNT by 1.
REQ-021 SHALL, on a tick with EN=1 and COUNT==0: set EXPIRED; if AUTORELOAD=1 load COUNT<=RELOAD, else clear EN and hold COUNT at 0.
REQ-022 SHALL give a bus write to COUNT priority over a same-cycle decrement or reload.
REQ-023 SHALL give a set of EXPIRED priority over a same-cycle write-1-to-clear.
REQ-024 SHALL give a hardware EN-clear priority over a same-cycle CTRL write to EN.
REQ-025 SHALL drive irq = EXPIRED && IRQ_EN, combinational from registers.
REQ-026 SHALL wrap COUNT arithmetic modulo 2^32; COUNT never underflows because 0 reloads or stops.

Reset
REQ-027 SHALL, while reset_n=0 at a clk edge, clear CTRL, PRESCALE, RELOAD, COUNT, EXPIRED, DUTY, the prescaler, the PWM counter and mem_ready, giving mem_rdata=0, irq=0 and pwm_out=0.
REQ-028 SHALL abandon any bus transfer in flight on reset, with no mem_ready issued for it.

Configuration
REQ-029 SHALL, when macro IOMEM_TIMER_PWM_EN is defined, implement an 8-bit pwm_cnt that increments (wrapping 255->0) on each tick while PWM_EN=1 and holds otherwise.
REQ-030 SHALL, with IOMEM_TIMER_PWM_EN defined, drive pwm_out[i] = PWM_EN && (pwm_cnt < DUTY[8i+7:8i]), registered; duty 0 gives constant low and duty 255 gives high for 255 of 256 ticks.
REQ-031 SHALL, with IOMEM_TIMER_PWM_EN undefined, omit pwm_cnt and DUTY storage, read DUTY as 0, tie pwm_out to 4'b0000, and ignore PWM_EN; the port list is unchanged.

Verification
REQ-032 SHALL cover: read CTRL at BASE+0x00 with mem_valid held high -> mem_ready high for exactly 1 cycle, 1 cycle after mem_valid, rdata 0; no second pulse.
REQ-033 SHALL cover: write RELOAD=0x12345678 with wstrb=4'b0101, then read it back -> 0x00340078.
REQ-034 SHALL cover: PRESCALE=2, COUNT=3, CTRL=0x5 -> EXPIRED and irq rise 12 cycles after the CTRL write, EN reads 0, and COUNT stays 0.
REQ-035 SHALL cover: CTRL=0x3, RELOAD=1, PRESCALE=0, then a STATUS write of 1 issued in the same cycle a 0-count tick sets EXPIRED -> EXPIRED reads 1 and COUNT reloads to 1.
REQ-036 SHALL cover: with IOMEM_TIMER_PWM_EN defined, DUTY=0xFF_80_01_00, PRESCALE=0, CTRL=0x8 -> over 256 cycles pwm_out[0..3] high for 0/1/128/255 cycles; with the macro undefined, pwm_out stays 0.
REQ-037 SHALL cover: assert reset_n=0 mid-count and mid-transfer -> all registers read 0 afterwards, no mem_ready for the aborted access, irq=0.

Source files
------------

// File: rtl/iomem_timer.sv
// iomem_timer: native-bus down-counting timer with prescaler, level IRQ and optional 4-channel PWM (enable with IOMEM_TIMER_PWM_EN)
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        irq,
  output logic [3:0]  pwm_out
);
  logic [3:0]  ctrl;
  logic [15:0] prescale;
  logic [15:0] psc;
  logic [31:0] reload;
  logic [31:0] count;
  logic [31:0] duty;
  logic [31:0] wmask;
  logic [31:0] rd_val;
  logic        expired;
  logic [2:0]  off;
  logic        sel;
  logic        acc;
  logic        wr;
  logic        pwm_on;
  logic        run;
  logic        tick;
  logic        expire;
  logic        unused;

  assign sel    = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
  assign acc    = sel && !mem_ready;
  assign wr     = acc && |mem_wstrb;
  assign off    = mem_addr[4:2];
  assign wmask  = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  assign run    = ctrl[0] || pwm_on;
  assign tick   = run && (psc == prescale);
  assign expire = tick && ctrl[0] && (count == 32'h0);
  assign irq    = expired && ctrl[2];
  assign unused = &{1'b0, mem_addr[1:0]};

  // Register read mux; holes and unused bits read as zero
  always_comb
    rd_val = (off == 3'd0) ? {28'h0, ctrl} :
             (off == 3'd1) ? {16'h0, prescale} :
             (off == 3'd2) ? reload :
             (off == 3'd3) ? count :
             (off == 3'd4) ? {31'h0, expired} :
             (off == 3'd5) ? duty : 32'h0;

  // One-cycle ready pulse per access; rdata only non-zero alongside ready
  always_ff @(posedge clk)
    if (!reset_n) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      mem_ready <= acc;
      mem_rdata <= acc ? rd_val : 32'h0;
    end

  // Timer registers: bus writes, prescaler, count/reload and expiry; later assignments win on conflicts
  always_ff @(posedge clk)
    if (!reset_n) begin
      ctrl     <= 4'h0;
      prescale <= 16'h0;
      reload   <= 32'h0;
      count    <= 32'h0;
      expired  <= 1'b0;
      psc      <= 16'h0;
    end else begin
      if (wr && off == 3'd0 && mem_wstrb[0]) ctrl <= mem_wdata[3:0];
      if (expire && !ctrl[1]) ctrl[0] <= 1'b0;
      if (wr && off == 3'd1) prescale <= (prescale & ~wmask[15:0]) | (mem_wdata[15:0] & wmask[15:0]);
      if (wr && off == 3'd2) reload <= (reload & ~wmask) | (mem_wdata & wmask);
      if (wr && off == 3'd3) count <= (count & ~wmask) | (mem_wdata & wmask);
      else if (expire) count <= ctrl[1] ? reload : 32'h0;
      else if (tick && ctrl[0]) count <= count - 32'd1;
      if (expire) expired <= 1'b1;
      else if (wr && off == 3'd4 && mem_wstrb[0] && mem_wdata[0]) expired <= 1'b0;
      psc <= (!run || tick) ? 16'h0 : psc + 16'd1;
    end

`ifdef IOMEM_TIMER_PWM_EN
  logic [7:0] pwm_cnt;

  assign pwm_on = ctrl[3];

  // PWM duty storage, tick-driven 8-bit phase counter and registered compare outputs
  always_ff @(posedge clk)
    if (!reset_n) begin
      duty    <= 32'h0;
      pwm_cnt <= 8'h0;
      pwm_out <= 4'h0;
    end else begin
      if (wr && off == 3'd5) duty <= (duty & ~wmask) | (mem_wdata & wmask);
      if (pwm_on && tick) pwm_cnt <= pwm_cnt + 8'd1;
      for (int i = 0; i < 4; i++) pwm_out[i] <= pwm_on && (pwm_cnt < duty[8*i +: 8]);
    end
`else
  assign pwm_on  = 1'b0;
  assign duty    = 32'h0;
  assign pwm_out = 4'h0;
`endif
endmodule

// File: tb/tb_iomem_timer.sv
// tb_iomem_timer: directed table-driven and sequence checks for iomem_timer
module tb_iomem_timer;
  localparam logic [31:0] BASE = 32'h0300_0000;
`ifdef IOMEM_TIMER_PWM_EN
  localparam logic [31:0] DUTY_EXP = 32'h1122_3344;
  localparam int PWM_EXP [4] = '{0, 1, 128, 255};
`else
  localparam logic [31:0] DUTY_EXP = 32'h0;
  localparam int PWM_EXP [4] = '{0, 0, 0, 0};
`endif

  typedef struct {
    bit          rd;
    logic [2:0]  off;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        irq;
  logic [3:0]  pwm_out;
  int          checks = 0;
  int          fails = 0;

  iomem_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_valid(mem_valid),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .irq(irq),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic xfer(input logic [2:0] off, input logic [31:0] wd, input logic [3:0] st, output logic [31:0] r);
    mem_valid = 1'b1;
    mem_addr = BASE | {27'h0, off, 2'b00};
    mem_wdata = wd;
    mem_wstrb = st;
    @(posedge clk);
    @(negedge clk);
    check("ready_pulse", mem_ready, 1);
    r = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic idle();
    @(negedge clk);
    check("ready_drop", mem_ready, 0);
    check("rdata_idle", mem_rdata, 0);
  endtask

  task automatic wr_reg(input logic [2:0] off, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    xfer(off, wd, st, r);
    idle();
  endtask

  task automatic rd_chk(input logic [2:0] off, input logic [31:0] exp, input string name);
    logic [31:0] r;
    xfer(off, 32'h0, 4'h0, r);
    check(name, r, exp);
    idle();
  endtask

  initial begin
    vec_t tbl[$];
    logic [31:0] d;
    int first;
    int cnt [4];
    tbl.push_back('{1'b0, 3'd0, 32'hFFFF_FFF6, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 3'd0, 32'h0, 4'h0, 32'h0000_0006});
    tbl.push_back('{1'b0, 3'd1, 32'hABCD_1234, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 3'd1, 32'h0, 4'h0, 32'h0000_1234});
    tbl.push_back('{1'b0, 3'd1, 32'h0000_FF00, 4'b0010, 32'h0});
    tbl.push_back('{1'b1, 3'd1, 32'h0, 4'h0, 32'h0000_FF34});
    tbl.push_back('{1'b0, 3'd2, 32'h1234_5678, 4'b0101, 32'h0});
    tbl.push_back('{1'b1, 3'd2, 32'h0, 4'h0, 32'h0034_0078});
    tbl.push_back('{1'b0, 3'd2, 32'hAABB_CCDD, 4'b1010, 32'h0});
    tbl.push_back('{1'b1, 3'd2, 32'h0, 4'h0, 32'hAA34_CC78});
    tbl.push_back('{1'b0, 3'd3, 32'hDEAD_BEEF, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 3'd3, 32'h0, 4'h0, 32'hDEAD_BEEF});
    tbl.push_back('{1'b0, 3'd6, 32'hFFFF_FFFF, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 3'd6, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b1, 3'd7, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 3'd4, 32'hFFFF_FFFF, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 3'd4, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 3'd5, 32'h1122_3344, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 3'd5, 32'h0, 4'h0, DUTY_EXP});
    tbl.push_back('{1'b0, 3'd0, 32'h0, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 3'd0, 32'h0, 4'h0, 32'h0});

    do_reset();
    check("reset_ready", mem_ready, 0);
    check("reset_rdata", mem_rdata, 0);
    check("reset_irq", irq, 0);
    check("reset_pwm", pwm_out, 0);

    // single ready pulse with mem_valid held high
    mem_valid = 1'b1;
    mem_addr = BASE;
    mem_wstrb = 4'h0;
    check("held_pre", mem_ready, 0);
    @(negedge clk);
    check("held_pulse", mem_ready, 1);
    check("held_rdata", mem_rdata, 0);
    @(negedge clk);
    check("held_no_second", mem_ready, 0);
    mem_valid = 1'b0;
    idle();

    // register map vectors
    for (int i = 0; i < tbl.size(); i++) begin
      xfer(tbl[i].off, tbl[i].wd, tbl[i].st, d);
      if (tbl[i].rd) check($sformatf("vec%0d", i), d, tbl[i].exp);
      idle();
    end

    // accesses outside the window are never acknowledged
    mem_valid = 1'b1;
    mem_addr = BASE + 32'h20;
    mem_wdata = 32'h6;
    mem_wstrb = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check("miss_above", mem_ready, 0);
    end
    mem_addr = 32'h0200_0000;
    repeat (2) begin
      @(negedge clk);
      check("miss_other", mem_ready, 0);
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(negedge clk);
    rd_chk(0, 32'h0, "miss_no_write");

    // one-shot expiry timing: PRESCALE=2, COUNT=3, CTRL=EN|IRQ_EN
    do_reset();
    wr_reg(1, 32'd2, 4'hF);
    wr_reg(3, 32'd3, 4'hF);
    xfer(0, 32'h5, 4'hF, d);
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (irq && first < 0) first = k;
    end
    check("irq_latency", first, 12);
    rd_chk(0, 32'h4, "oneshot_en_clear");
    rd_chk(3, 32'h0, "oneshot_count");
    rd_chk(4, 32'h1, "oneshot_expired");
    repeat (10) @(negedge clk);
    rd_chk(3, 32'h0, "oneshot_count_hold");
    wr_reg(4, 32'h1, 4'b1110);
    rd_chk(4, 32'h1, "w1c_wrong_lane");
    check("irq_still_set", irq, 1);
    wr_reg(4, 32'h1, 4'hF);
    rd_chk(4, 32'h0, "w1c_clear");
    check("irq_cleared", irq, 0);

    // hardware EN clear beats a same-cycle CTRL write of EN=1
    do_reset();
    wr_reg(3, 32'd1, 4'hF);
    wr_reg(0, 32'h1, 4'hF);
    wr_reg(0, 32'h1, 4'hF);
    rd_chk(0, 32'h0, "hw_en_clear_prio");
    rd_chk(4, 32'h1, "hw_en_expired");

    // bus COUNT write beats a same-cycle decrement
    do_reset();
    wr_reg(2, 32'h1000, 4'hF);
    wr_reg(0, 32'h3, 4'hF);
    wr_reg(3, 32'h50, 4'hF);
    rd_chk(3, 32'h4F, "count_wr_prio");
    wr_reg(0, 32'h0, 4'hF);

    // EXPIRED set beats a same-cycle write-1-to-clear; autoreload to 1
    do_reset();
    wr_reg(2, 32'd1, 4'hF);
    wr_reg(1, 32'd0, 4'hF);
    wr_reg(0, 32'h3, 4'hF);
    @(negedge clk);
    xfer(4, 32'h1, 4'hF, d);
    check("expired_set_prio", dut.expired, 1);
    check("count_reload", dut.count, 1);
    @(negedge clk);
    xfer(0, 32'h0, 4'hF, d);
    idle();
    rd_chk(4, 32'h1, "expired_after_stop");
    wr_reg(4, 32'h1, 4'hF);
    rd_chk(4, 32'h0, "expired_clear");
    rd_chk(3, 32'h1, "count_after_stop");

    // PWM duty cycles over one full 256-tick period
    do_reset();
    wr_reg(5, 32'hFF80_0100, 4'hF);
    wr_reg(0, 32'h8, 4'hF);
    cnt = '{0, 0, 0, 0};
    for (int i = 0; i < 256; i++) begin
      for (int c = 0; c < 4; c++) cnt[c] += int'(pwm_out[c]);
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) check($sformatf("pwm_ch%0d", c), cnt[c], PWM_EXP[c]);

    // reset while counting and mid-transfer
    do_reset();
    wr_reg(1, 32'd3, 4'hF);
    wr_reg(5, 32'hFFFF_FFFF, 4'hF);
    wr_reg(2, 32'h100, 4'hF);
    wr_reg(0, 32'hF, 4'hF);
    repeat (8) @(negedge clk);
    check("irq_pre_reset", irq, 1);
    mem_valid = 1'b1;
    mem_addr = BASE | 32'hC;
    mem_wstrb = 4'h0;
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_no_ready", mem_ready, 0);
    mem_valid = 1'b0;
    @(negedge clk);
    check("abort_no_ready2", mem_ready, 0);
    reset_n = 1'b1;
    check("abort_irq", irq, 0);
    check("abort_pwm", pwm_out, 0);
    check("abort_rdata", mem_rdata, 0);
    @(negedge clk);
    check("abort_no_late_ready", mem_ready, 0);
    for (int o = 0; o < 8; o++) rd_chk(o[2:0], 32'h0, $sformatf("post_reset_reg%0d", o));
    check("post_reset_irq", irq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
